// File: rtl/mmu_systolic_2x2.sv
// 2x2 output-stationary systolic multiply C = A x B on signed operands; optional MMU_SATURATE_EN clamps accumulates.
// Latency: done rises 4 edges after the start-accepting edge; busy is high for exactly those 4 cycles.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while RUN.
module mmu_systolic_2x2 #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DATA_W-1:0] a_flat,
    input  logic [4*DATA_W-1:0] b_flat,
    output logic [4*ACC_W-1:0]  c_flat,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                step_q, step_d;
    logic signed [DATA_W-1:0]  a_op_q [2][2];
    logic signed [DATA_W-1:0]  a_op_d [2][2];
    logic signed [DATA_W-1:0]  b_op_q [2][2];
    logic signed [DATA_W-1:0]  b_op_d [2][2];
    // Only the left column's a and top row's b hops have a downstream consumer.
    logic signed [DATA_W-1:0]  a_pass_q [2];
    logic signed [DATA_W-1:0]  a_pass_d [2];
    logic signed [DATA_W-1:0]  b_pass_q [2];
    logic signed [DATA_W-1:0]  b_pass_d [2];
    logic signed [ACC_W-1:0]   acc_q [2][2];
    logic signed [ACC_W-1:0]   acc_d [2][2];
    logic signed [DATA_W-1:0]  row_feed [2];
    logic signed [DATA_W-1:0]  col_feed [2];
    logic signed [DATA_W-1:0]  pe_a [2][2];
    logic signed [DATA_W-1:0]  pe_b [2][2];

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] prod;
`ifdef MMU_SATURATE_EN
        logic signed [ACC_W:0]      sum;
        prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
        if (sum[ACC_W] != sum[ACC_W-1])
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return sum[ACC_W-1:0];
`else
        logic signed [ACC_W-1:0]    sum;
        prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        sum  = acc + ACC_W'(prod);
        return sum;
`endif
    endfunction

    // Skewed edge feeds: row i lags by i steps, column j lags by j steps.
    always_comb begin
        row_feed[0] = '0;
        row_feed[1] = '0;
        col_feed[0] = '0;
        col_feed[1] = '0;
        case (step_q)
            2'd0: begin
                row_feed[0] = a_op_q[0][0];
                col_feed[0] = b_op_q[0][0];
            end
            2'd1: begin
                row_feed[0] = a_op_q[0][1];
                row_feed[1] = a_op_q[1][0];
                col_feed[0] = b_op_q[1][0];
                col_feed[1] = b_op_q[0][1];
            end
            2'd2: begin
                row_feed[1] = a_op_q[1][1];
                col_feed[1] = b_op_q[1][1];
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                pe_a[i][j] = (j == 0) ? row_feed[i] : a_pass_q[i];
                pe_b[i][j] = (i == 0) ? col_feed[j] : b_pass_q[j];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        a_op_d   = a_op_q;
        b_op_d   = b_op_q;
        a_pass_d = a_pass_q;
        b_pass_d = b_pass_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    step_d  = 2'd0;
                    for (int i = 0; i < 2; i++) begin
                        a_pass_d[i] = '0;
                        b_pass_d[i] = '0;
                        for (int j = 0; j < 2; j++) begin
                            a_op_d[i][j] = a_flat[DATA_W*(2*i+j) +: DATA_W];
                            b_op_d[i][j] = b_flat[DATA_W*(2*i+j) +: DATA_W];
                            acc_d[i][j]  = '0;
                        end
                    end
                end
            end
            RUN: begin
                step_d = step_q + 2'd1;
                for (int i = 0; i < 2; i++) begin
                    a_pass_d[i] = row_feed[i];
                    b_pass_d[i] = col_feed[i];
                    for (int j = 0; j < 2; j++)
                        acc_d[i][j] = mac(acc_q[i][j], pe_a[i][j], pe_b[i][j]);
                end
                if (step_q == 2'd3)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                a_pass_q[i] <= '0;
                b_pass_q[i] <= '0;
                for (int j = 0; j < 2; j++) begin
                    a_op_q[i][j] <= '0;
                    b_op_q[i][j] <= '0;
                    acc_q[i][j]  <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            a_op_q   <= a_op_d;
            b_op_q   <= b_op_d;
            a_pass_q <= a_pass_d;
            b_pass_q <= b_pass_d;
            acc_q    <= acc_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_row
        for (genvar gj = 0; gj < 2; gj++) begin : g_col
            assign c_flat[ACC_W*(2*gi+gj) +: ACC_W] = acc_q[gi][gj];
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
